draw_rect_img: RTL
==================

DRAW_RECT_IMG -- requirements
Module: draw_rect_img

Interface
REQ-001 Parameter RECT_WIDTH, default 48, image width in pixels (1..64).
REQ-002 Parameter RECT_HEIGHT, default 64, image height in pixels (1..64).
REQ-003 Parameter KEY_COLOR, default 12'hF0F, transparent colour: ROM pixels equal to it are not drawn.
REQ-004 clk  in  1  pixel clock; all logic rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 hcount_in, vcount_in  in  11 each  current pixel coordinates from the timing/background stage.
REQ-007 hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  sync and blanking strobes aligned with hcount_in/vcount_in.
REQ-008 rgb_in  in  12  background pixel colour {r,g,b}.
REQ-009 xpos, ypos  in  12 each  requested top-left corner of the image on screen.
REQ-010 pixel_addr  out  12  image ROM address {rel_y[5:0], rel_x[5:0]}.
REQ-011 rgb_pixel  in  12  image ROM data, valid one clk after pixel_addr (registered ROM).
REQ-012 hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out  out  11/11/1/1/1/1  timing delayed to align with rgb_out.
REQ-013 rgb_out  out  12  composited pixel colour.

Function
REQ-014 Total latency input->output SHALL be exactly 2 clk for every timing output and rgb_out.
REQ-015 Position latch: xpos_l/ypos_l SHALL load xpos/ypos only on the cycle vblnk_in rises (vblnk_in=1, previous vblnk_in=0); otherwise they hold, so the image never tears mid-frame.
REQ-016 Stage 1 (registered): rel_x = hcount_in - xpos_l, rel_y = vcount_in - ypos_l, computed at 13 bits; in_rect_s1 = (hcount_in >= xpos_l) AND (hcount_in < xpos_l + RECT_WIDTH) AND (vcount_in >= ypos_l) AND (vcount_in < ypos_l + RECT_HEIGHT), comparisons at 13 bits with no wrap.
REQ-017 pixel_addr SHALL be registered in stage 1 as {rel_y[5:0], rel_x[5:0]} when in_rect, and 12'h000 otherwise.
REQ-018 Stage 1 SHALL also register hcount, vcount, syncs, blanks, rgb_in and the combined blank flag (hblnk_in OR vblnk_in).
REQ-019 Stage 2 (registered) SHALL copy stage-1 timing to the *_out ports and select rgb_out: 12'h000 if stage-1 blank flag set; else rgb_pixel if in_rect_s1 and rgb_pixel != KEY_COLOR; else stage-1 rgb.
REQ-020 An image partially off-screen (xpos_l + RECT_WIDTH > 1023 or similar) SHALL be clipped naturally; no pixel outside the rectangle SHALL change.
REQ-021 xpos/ypos changing on the same cycle as the vblnk_in rising edge SHALL be captured with the new value.
REQ-022 No handshake: one pixel per clk is accepted and produced every cycle, no stalls.

Reset
REQ-023 While rst=1 at a clk edge, all stage registers, pixel_addr, rgb_out, every *_out port, xpos_l, ypos_l and the vblnk edge detector SHALL be cleared to 0.
REQ-024 After rst deasserts mid-frame, xpos_l/ypos_l SHALL stay 0 until the next vblnk_in rising edge; the pipeline SHALL produce valid outputs from the 3rd clk after release.

Verification
REQ-025 Latency: drive hcount_in=100, vcount_in=200, hsync_in=1 on one cycle -> same values appear on *_out exactly 2 clk later.
REQ-026 Addressing: xpos=ypos=10 latched, hcount_in=15, vcount_in=12 -> pixel_addr=12'h085 ({6'd2,6'd5}) next clk; with ROM model returning 12'h123 -> rgb_out=12'h123 two clk after input.
REQ-027 Boundaries: xpos=10 latched: hcount_in=9 and hcount_in=58 -> rgb_out=rgb_in delayed; hcount_in=10 and 57 -> ROM pixel; same for vcount at ypos and ypos+63.
REQ-028 Transparency/blanking: ROM returns 12'hF0F inside rect -> rgb_out=rgb_in delayed; hblnk_in=1 inside rect -> rgb_out=12'h000.
REQ-029 Frame latch: change xpos 10->300 mid-frame -> drawing stays at x=10 until vblnk_in rises, then x=300 from the next active line.
REQ-030 Reset: assert rst for 1 clk mid-line -> all outputs 0 next clk; xpos_l=0 until next vblnk_in rising edge.

Source files
------------

// File: rtl/draw_rect_img.sv
// Overlays a rectangular ROM image onto the incoming pixel stream.
// Two-stage pipeline: stage 1 forms the ROM address, stage 2 composites the ROM pixel.
module draw_rect_img #(
  parameter int unsigned RECT_WIDTH  = 48,
  parameter int unsigned RECT_HEIGHT = 64,
  parameter logic [11:0] KEY_COLOR   = 12'hF0F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  output logic [11:0] pixel_addr,
  input  logic [11:0] rgb_pixel,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  logic        vblnk_prev_q, vblnk_prev_d;
  logic [11:0] xpos_l_q, xpos_l_d, ypos_l_q, ypos_l_d;

  logic [10:0] hcount_s1_q, hcount_s1_d, vcount_s1_q, vcount_s1_d;
  logic        hsync_s1_q, hsync_s1_d, vsync_s1_q, vsync_s1_d;
  logic        hblnk_s1_q, hblnk_s1_d, vblnk_s1_q, vblnk_s1_d;
  logic        blank_s1_q, blank_s1_d, in_rect_s1_q, in_rect_s1_d;
  logic [11:0] rgb_s1_q, rgb_s1_d, pixel_addr_q, pixel_addr_d;

  logic [10:0] hcount_s2_q, hcount_s2_d, vcount_s2_q, vcount_s2_d;
  logic        hsync_s2_q, hsync_s2_d, vsync_s2_q, vsync_s2_d;
  logic        hblnk_s2_q, hblnk_s2_d, vblnk_s2_q, vblnk_s2_d;
  logic [11:0] rgb_s2_q, rgb_s2_d;

  logic [12:0] h13, v13, x13, y13, x_end, y_end;
  logic [5:0]  rel_x, rel_y;
  logic        in_rect;

  always_comb begin
    vblnk_prev_d = vblnk_in;
    xpos_l_d     = xpos_l_q;
    ypos_l_d     = ypos_l_q;
    // Position only moves at the start of vertical blanking so a frame never tears.
    if (vblnk_in && !vblnk_prev_q) begin
      xpos_l_d = xpos;
      ypos_l_d = ypos;
    end

    h13     = {2'b00, hcount_in};
    v13     = {2'b00, vcount_in};
    x13     = {1'b0, xpos_l_q};
    y13     = {1'b0, ypos_l_q};
    x_end   = x13 + 13'(RECT_WIDTH);
    y_end   = y13 + 13'(RECT_HEIGHT);
    in_rect = (h13 >= x13) && (h13 < x_end) && (v13 >= y13) && (v13 < y_end);
    // Only the low six bits of the offsets reach the ROM address.
    rel_x   = hcount_in[5:0] - xpos_l_q[5:0];
    rel_y   = vcount_in[5:0] - ypos_l_q[5:0];

    hcount_s1_d  = hcount_in;
    vcount_s1_d  = vcount_in;
    hsync_s1_d   = hsync_in;
    vsync_s1_d   = vsync_in;
    hblnk_s1_d   = hblnk_in;
    vblnk_s1_d   = vblnk_in;
    blank_s1_d   = hblnk_in | vblnk_in;
    rgb_s1_d     = rgb_in;
    in_rect_s1_d = in_rect;
    pixel_addr_d = in_rect ? {rel_y, rel_x} : '0;

    hcount_s2_d = hcount_s1_q;
    vcount_s2_d = vcount_s1_q;
    hsync_s2_d  = hsync_s1_q;
    vsync_s2_d  = vsync_s1_q;
    hblnk_s2_d  = hblnk_s1_q;
    vblnk_s2_d  = vblnk_s1_q;
    if (blank_s1_q)
      rgb_s2_d = '0;
    else if (in_rect_s1_q && (rgb_pixel != KEY_COLOR))
      rgb_s2_d = rgb_pixel;
    else
      rgb_s2_d = rgb_s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_prev_q <= 1'b0;
      xpos_l_q     <= '0;
      ypos_l_q     <= '0;
      hcount_s1_q  <= '0;
      vcount_s1_q  <= '0;
      hsync_s1_q   <= 1'b0;
      vsync_s1_q   <= 1'b0;
      hblnk_s1_q   <= 1'b0;
      vblnk_s1_q   <= 1'b0;
      blank_s1_q   <= 1'b0;
      in_rect_s1_q <= 1'b0;
      rgb_s1_q     <= '0;
      pixel_addr_q <= '0;
      hcount_s2_q  <= '0;
      vcount_s2_q  <= '0;
      hsync_s2_q   <= 1'b0;
      vsync_s2_q   <= 1'b0;
      hblnk_s2_q   <= 1'b0;
      vblnk_s2_q   <= 1'b0;
      rgb_s2_q     <= '0;
    end else begin
      vblnk_prev_q <= vblnk_prev_d;
      xpos_l_q     <= xpos_l_d;
      ypos_l_q     <= ypos_l_d;
      hcount_s1_q  <= hcount_s1_d;
      vcount_s1_q  <= vcount_s1_d;
      hsync_s1_q   <= hsync_s1_d;
      vsync_s1_q   <= vsync_s1_d;
      hblnk_s1_q   <= hblnk_s1_d;
      vblnk_s1_q   <= vblnk_s1_d;
      blank_s1_q   <= blank_s1_d;
      in_rect_s1_q <= in_rect_s1_d;
      rgb_s1_q     <= rgb_s1_d;
      pixel_addr_q <= pixel_addr_d;
      hcount_s2_q  <= hcount_s2_d;
      vcount_s2_q  <= vcount_s2_d;
      hsync_s2_q   <= hsync_s2_d;
      vsync_s2_q   <= vsync_s2_d;
      hblnk_s2_q   <= hblnk_s2_d;
      vblnk_s2_q   <= vblnk_s2_d;
      rgb_s2_q     <= rgb_s2_d;
    end
  end

  assign pixel_addr = pixel_addr_q;
  assign hcount_out = hcount_s2_q;
  assign vcount_out = vcount_s2_q;
  assign hsync_out  = hsync_s2_q;
  assign vsync_out  = vsync_s2_q;
  assign hblnk_out  = hblnk_s2_q;
  assign vblnk_out  = vblnk_s2_q;
  assign rgb_out    = rgb_s2_q;

endmodule
